button_conditioner: RTL and testbench

Conditions the raw push-button inputs of the VGA test top level into clean, single-cycle events on the 25 MHz pixel clock. Each button passes through a two-flop synchronizer, a per-button debounce state machine and an edge generator. The block sits directly upstream of the section-select FSM and colour painter. Those stages consume one-cycle press pulses in the pixel-clock domain instead of using the mechanical buttons as clocks.

---
 rtl/button_conditioner_if.sv | 12 +
 rtl/button_conditioner.sv | 107 ++++++++++
 tb/tb_button_conditioner.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/button_conditioner_if.sv
// Button bundle between the raw board pins and the debounced event consumers.
interface button_conditioner_if #(
    parameter int N_BTN = 2
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;

    modport master (output btn_raw, input btn_level, btn_press, btn_release);
    modport slave  (input btn_raw, output btn_level, btn_press, btn_release);
endinterface

// File: rtl/button_conditioner.sv
// Per-button synchronizer, debounce FSM and press/release pulse generator,
// producing clean single-cycle events in the pixel-clock domain.
module button_conditioner #(
    parameter int N_BTN           = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    button_conditioner_if.slave btn
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_TERM = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    localparam logic [1:0] RELEASED     = 2'd0;
    localparam logic [1:0] PRESS_WAIT   = 2'd1;
    localparam logic [1:0] PRESSED      = 2'd2;
    localparam logic [1:0] RELEASE_WAIT = 2'd3;

    logic [N_BTN-1:0] raw_in;
    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] sync;
    logic [N_BTN-1:0] level;
    logic [N_BTN-1:0] press;
    logic [N_BTN-1:0] release_p;

    assign raw_in = btn.btn_raw ^ {N_BTN{BTN_ACTIVE_LOW}};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync  <= '0;
        end else begin
            sync1 <= raw_in;
            sync  <= sync1;
        end
    end

    for (genvar g = 0; g < N_BTN; g++) begin : g_btn
        logic [1:0]    state;
        logic [CW-1:0] cnt;
        logic          press_q;
        logic          release_q;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state     <= RELEASED;
                cnt       <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                press_q   <= 1'b0;
                release_q <= 1'b0;
                case (state)
                    RELEASED: begin
                        if (sync[g]) begin
                            state <= PRESS_WAIT;
                            cnt   <= CW'(1);
                        end else begin
                            cnt <= '0;
                        end
                    end
                    PRESS_WAIT: begin
                        if (!sync[g]) begin
                            state <= RELEASED;
                            cnt   <= '0;
                        end else if (cnt == CNT_TERM) begin
                            state   <= PRESSED;
                            cnt     <= '0;
                            press_q <= 1'b1;
                        end else if (cnt != CNT_MAX) begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    PRESSED: begin
                        if (!sync[g]) begin
                            state <= RELEASE_WAIT;
                            cnt   <= CW'(1);
                        end
                    end
                    RELEASE_WAIT: begin
                        if (sync[g]) begin
                            state <= PRESSED;
                            cnt   <= '0;
                        end else if (cnt == CNT_TERM) begin
                            state     <= RELEASED;
                            cnt       <= '0;
                            release_q <= 1'b1;
                        end else if (cnt != CNT_MAX) begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                endcase
            end
        end

        // PRESSED and RELEASE_WAIT are the two states with bit 1 set.
        assign level[g]     = state[1];
        assign press[g]     = press_q;
        assign release_p[g] = release_q;
    end

    assign btn.btn_level   = level;
    assign btn.btn_press   = press;
    assign btn.btn_release = release_p;
endmodule

// File: tb/tb_button_conditioner.sv
// Randomized and directed bench for button_conditioner against a
// stable-run-length reference model (D consecutive differing samples flip the level).
module tb_button_conditioner;
    localparam int N = 2;
    localparam int D = 8;

    logic clk;
    logic rst_n;

    button_conditioner_if #(.N_BTN(N)) bif ();

    button_conditioner #(
        .N_BTN(N),
        .DEBOUNCE_CYCLES(D),
        .BTN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .reset(rst_n),
        .btn(bif)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    bit [1:0] q[$];
    bit [1:0] m_level;
    bit [1:0] m_press;
    bit [1:0] m_rel;
    int       run[N];

    // One clock: sampled synchronizer output lags the raw pin by two edges.
    task automatic tick();
        bit [1:0] sp;
        @(posedge clk);
        m_press = '0;
        m_rel   = '0;
        if (!rst_n) begin
            q = '{2'b00, 2'b00};
            m_level = '0;
            for (int b = 0; b < N; b++) run[b] = 0;
        end else begin
            sp = q.pop_front();
            q.push_back(~bif.btn_raw);
            for (int b = 0; b < N; b++) begin
                if (sp[b] != m_level[b]) begin
                    run[b]++;
                    if (run[b] == D) begin
                        m_level[b] = ~m_level[b];
                        run[b] = 0;
                        if (m_level[b]) m_press[b] = 1'b1;
                        else m_rel[b] = 1'b1;
                    end
                end else begin
                    run[b] = 0;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        int npress;
        bif.btn_raw = 2'b00;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({bif.btn_level, bif.btn_press, bif.btn_release} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_async got %b want 000000", {bif.btn_level, bif.btn_press, bif.btn_release});
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if ({bif.btn_level, bif.btn_press, bif.btn_release} !== 6'b0) begin
                miscompares++;
                $display("FAIL reset_hold got %b want 000000", {bif.btn_level, bif.btn_press, bif.btn_release});
            end
        end
        rst_n = 1'b1;
        npress = 0;
        for (int k = 1; k <= 14; k++) begin
            tick();
            npress += (bif.btn_press != 2'b00) ? 1 : 0;
            vectors++;
            if ({bif.btn_level, bif.btn_press, bif.btn_release} !== {m_level, m_press, m_rel}) begin
                miscompares++;
                $display("FAIL reset_model k=%0d got %b want %b", k, {bif.btn_level, bif.btn_press, bif.btn_release}, {m_level, m_press, m_rel});
            end
            if (k == 10) begin
                vectors++;
                if (bif.btn_press !== 2'b11 || bif.btn_level !== 2'b11) begin
                    miscompares++;
                    $display("FAIL reset_press_edge press=%b level=%b want 11/11", bif.btn_press, bif.btn_level);
                end
            end
        end
        vectors++;
        if (npress != 1) begin
            miscompares++;
            $display("FAIL reset_press_count got %0d want 1", npress);
        end
    endtask

    task automatic test_clean_press();
        bif.btn_raw = 2'b11;
        for (int k = 0; k < 14; k++) begin
            tick();
            vectors++;
            if ({bif.btn_level, bif.btn_press, bif.btn_release} !== {m_level, m_press, m_rel}) begin
                miscompares++;
                $display("FAIL settle_model got %b want %b", {bif.btn_level, bif.btn_press, bif.btn_release}, {m_level, m_press, m_rel});
            end
        end
        bif.btn_raw[0] = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            tick();
            vectors++;
            if (bif.btn_press[0] !== (k == 10) || bif.btn_level[0] !== (k >= 10) ||
                {bif.btn_level[1], bif.btn_press[1], bif.btn_release[1]} !== 3'b000) begin
                miscompares++;
                $display("FAIL clean_press k=%0d press=%b level=%b rel=%b", k, bif.btn_press, bif.btn_level, bif.btn_release);
            end
        end
        bif.btn_raw[0] = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            tick();
            vectors++;
            if (bif.btn_release[0] !== (k == 10) || bif.btn_level[0] !== (k < 10) || bif.btn_press !== 2'b00 ||
                {bif.btn_level[1], bif.btn_release[1]} !== 2'b00) begin
                miscompares++;
                $display("FAIL clean_release k=%0d press=%b level=%b rel=%b", k, bif.btn_press, bif.btn_level, bif.btn_release);
            end
        end
    endtask

    task automatic test_bounce();
        int npulse = 0;
        for (int c = 0; c < 40; c++) begin
            if (c % 3 == 0) bif.btn_raw[0] = ~bif.btn_raw[0];
            tick();
            npulse += (bif.btn_press[0] | bif.btn_release[0]) ? 1 : 0;
            vectors++;
            if ({bif.btn_level, bif.btn_press, bif.btn_release} !== {m_level, m_press, m_rel}) begin
                miscompares++;
                $display("FAIL bounce_model c=%0d got %b want %b", c, {bif.btn_level, bif.btn_press, bif.btn_release}, {m_level, m_press, m_rel});
            end
        end
        vectors++;
        if (npulse != 0) begin
            miscompares++;
            $display("FAIL bounce_pulses got %0d want 0", npulse);
        end
        bif.btn_raw[0] = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            tick();
            vectors++;
            if (bif.btn_press[0] !== (k == 10)) begin
                miscompares++;
                $display("FAIL bounce_settle k=%0d press0=%b want %b", k, bif.btn_press[0], (k == 10));
            end
        end
    endtask

    task automatic test_glitch();
        bif.btn_raw = 2'b11;
        for (int k = 0; k < 14; k++) tick();
        bif.btn_raw[1] = 1'b0;
        for (int k = 0; k < 27; k++) begin
            if (k == 7) bif.btn_raw[1] = 1'b1;
            tick();
            vectors++;
            if ({bif.btn_level[1], bif.btn_press[1], bif.btn_release[1]} !== 3'b000 ||
                {bif.btn_level, bif.btn_press, bif.btn_release} !== {m_level, m_press, m_rel}) begin
                miscompares++;
                $display("FAIL glitch k=%0d got %b want %b", k, {bif.btn_level, bif.btn_press, bif.btn_release}, {m_level, m_press, m_rel});
            end
        end
    endtask

    task automatic test_long_hold();
        int npress = 0;
        int bad_level = 0;
        bif.btn_raw[0] = 1'b0;
        for (int k = 1; k <= 10000; k++) begin
            tick();
            npress += bif.btn_press[0] ? 1 : 0;
            if (bif.btn_level[0] !== (k >= 10)) bad_level++;
            vectors++;
            if ({bif.btn_level, bif.btn_press, bif.btn_release} !== {m_level, m_press, m_rel}) begin
                miscompares++;
                $display("FAIL hold_model k=%0d got %b want %b", k, {bif.btn_level, bif.btn_press, bif.btn_release}, {m_level, m_press, m_rel});
            end
        end
        vectors++;
        if (npress != 1 || bad_level != 0) begin
            miscompares++;
            $display("FAIL long_hold presses=%0d bad_level_cycles=%0d want 1/0", npress, bad_level);
        end
        bif.btn_raw = 2'b11;
        for (int k = 0; k < 14; k++) tick();
    endtask

    task automatic test_mid_reset();
        int npress = 0;
        bif.btn_raw[0] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            npress += bif.btn_press[0] ? 1 : 0;
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({bif.btn_level, bif.btn_press, bif.btn_release} !== 6'b0) begin
            miscompares++;
            $display("FAIL midreset_clear got %b want 000000", {bif.btn_level, bif.btn_press, bif.btn_release});
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            npress += bif.btn_press[0] ? 1 : 0;
        end
        rst_n = 1'b1;
        vectors++;
        if (npress != 0) begin
            miscompares++;
            $display("FAIL midreset_early_press got %0d want 0", npress);
        end
        for (int k = 1; k <= 14; k++) begin
            tick();
            vectors++;
            if (bif.btn_press[0] !== (k == 10) ||
                {bif.btn_level, bif.btn_press, bif.btn_release} !== {m_level, m_press, m_rel}) begin
                miscompares++;
                $display("FAIL midreset_press k=%0d got %b want %b", k, {bif.btn_level, bif.btn_press, bif.btn_release}, {m_level, m_press, m_rel});
            end
        end
    endtask

    task automatic test_random();
        int hold[N];
        for (int b = 0; b < N; b++) hold[b] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++) begin
                if (hold[b] == 0) begin
                    bif.btn_raw[b] = 1'($urandom_range(0, 1));
                    hold[b] = $urandom_range(1, 14);
                end
                hold[b]--;
            end
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
            tick();
            vectors++;
            if ({bif.btn_level, bif.btn_press, bif.btn_release} !== {m_level, m_press, m_rel}) begin
                miscompares++;
                $display("FAIL random_model c=%0d got %b want %b", c, {bif.btn_level, bif.btn_press, bif.btn_release}, {m_level, m_press, m_rel});
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        bif.btn_raw = 2'b11;
        q = '{2'b00, 2'b00};
        m_level = '0;
        m_press = '0;
        m_rel = '0;
        for (int b = 0; b < N; b++) run[b] = 0;
        #5;
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_long_hold();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
